// File: rtl/paralelo_serial_tx.sv
// Byte-to-bit serialiser behind the 2:1 byte mux: COM training after reset, then data/IDLE bytes, MSB first.
// Optional build macro SCRAMBLE_EN adds a 16-bit LFSR scrambler on valid data bytes.
module paralelo_serial_tx #(
    parameter int unsigned TRAIN_FRAMES = 4,
    parameter logic [7:0]  COM_SYM      = 8'hBC,
    parameter logic [7:0]  IDLE_SYM     = 8'h7C
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       data_out,
    output logic       byte_strobe,
    output logic       active
);

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned TRAIN_W = 4;

    localparam logic [TRAIN_W-1:0] TRAIN_LAST = TRAIN_W'(TRAIN_FRAMES - 1);
    localparam logic [TRAIN_W-1:0] TRAIN_SAT  = '1;

`ifdef SCRAMBLE_EN
    localparam int unsigned LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_POLY = 16'h0039;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hFFFF;

    // Advance the Galois LFSR by one byte (8 single steps).
    function automatic logic [LFSR_W-1:0] lfsr_step8(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] r;
        r = s;
        for (int i = 0; i < 8; i++) begin
            r = {r[LFSR_W-2:0], 1'b0} ^ (r[LFSR_W-1] ? LFSR_POLY : '0);
        end
        return r;
    endfunction

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
`endif

    typedef enum logic {
        S_TRAIN  = 1'b0,
        S_ACTIVE = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]  shift_q, shift_d;
    logic [TRAIN_W-1:0] train_cnt_q, train_cnt_d;
    logic               data_out_q, data_out_d;
    logic               strobe_q, strobe_d;
    logic               active_q, active_d;
    logic [BYTE_W-1:0]  sel;
    logic               sample;

    assign sample = (bit_cnt_q == '0);

    // State register and output flops.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= S_TRAIN;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            train_cnt_q <= '0;
            data_out_q  <= 1'b0;
            strobe_q    <= 1'b0;
            active_q    <= 1'b0;
`ifdef SCRAMBLE_EN
            lfsr_q      <= LFSR_SEED;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            train_cnt_q <= train_cnt_d;
            data_out_q  <= data_out_d;
            strobe_q    <= strobe_d;
            active_q    <= active_d;
`ifdef SCRAMBLE_EN
            lfsr_q      <= lfsr_d;
`endif
        end
    end

    // Next state: byte selection at sample edges, shifting in between.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = CNT_W'(bit_cnt_q + 1'b1);
        shift_d     = {shift_q[BYTE_W-2:0], 1'b0};
        train_cnt_d = train_cnt_q;
        data_out_d  = shift_q[BYTE_W-1];
        strobe_d    = 1'b0;
        active_d    = active_q;
        sel         = IDLE_SYM;
`ifdef SCRAMBLE_EN
        lfsr_d      = lfsr_q;
`endif

        if (sample) begin
            case (state_q)
                S_TRAIN: begin
                    sel = COM_SYM;
                    if (train_cnt_q != TRAIN_SAT) begin
                        train_cnt_d = TRAIN_W'(train_cnt_q + 1'b1);
                    end
                    if (train_cnt_q == TRAIN_LAST) begin
                        state_d  = S_ACTIVE;
                        active_d = 1'b1;
                    end
`ifdef SCRAMBLE_EN
                    lfsr_d = LFSR_SEED;
`endif
                end
                S_ACTIVE: begin
`ifdef SCRAMBLE_EN
                    sel    = valid_in ? (data_in ^ lfsr_q[LFSR_W-1 -: BYTE_W]) : IDLE_SYM;
                    lfsr_d = lfsr_step8(lfsr_q);
`else
                    sel = valid_in ? data_in : IDLE_SYM;
`endif
                end
                default: state_d = S_TRAIN;
            endcase
            shift_d    = {sel[BYTE_W-2:0], 1'b0};
            data_out_d = sel[BYTE_W-1];
            strobe_d   = 1'b1;
        end
    end

    assign data_out    = data_out_q;
    assign byte_strobe = strobe_q;
    assign active      = active_q;

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Self-checking bench for paralelo_serial_tx: table of byte slots plus reset-mid-byte sequence.
// Build with SCRAMBLE_EN defined to also check the scrambled data path.
module tb_paralelo_serial_tx;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       data_out;
    logic       byte_strobe;
    logic       active;

    int errors = 0;
    int checks = 0;
    logic [15:0] m_lfsr = 16'hFFFF;

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic [7:0] exp;
        logic       act;
        logic       com;
    } vec_t;

    paralelo_serial_tx dut (
        .clk         (clk),
        .reset_L     (reset_L),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .data_out    (data_out),
        .byte_strobe (byte_strobe),
        .active      (active)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [7:0] act_v, input logic [7:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
        end
    endtask

    function automatic logic [15:0] model_step8(input logic [15:0] s);
        logic [15:0] r;
        r = s;
        for (int i = 0; i < 8; i++) begin
            if (r[15]) r = {r[14:0], 1'b0} ^ 16'h0039;
            else       r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    // Drive one byte slot and check nbits serial cycles; inputs are randomised off the sample edge.
    task automatic send_byte(input vec_t r, input string tag, input int nbits);
        logic [7:0] e;
        e = r.exp;
`ifdef SCRAMBLE_EN
        if (r.com) begin
            m_lfsr = 16'hFFFF;
        end else begin
            if (r.v) e = e ^ m_lfsr[15:8];
            m_lfsr = model_step8(m_lfsr);
        end
`endif
        for (int j = 0; j < nbits; j++) begin
            if (j == 0) begin
                data_in  = r.d;
                valid_in = r.v;
            end else begin
                data_in  = 8'($urandom);
                valid_in = 1'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("%s bit%0d data_out", tag, 7 - j), 8'(data_out), 8'(e[7 - j]));
            chk($sformatf("%s bit%0d strobe", tag, 7 - j), 8'(byte_strobe), 8'(j == 0));
            chk($sformatf("%s bit%0d active", tag, 7 - j), 8'(active), 8'(r.act));
        end
    endtask

    vec_t tbl[10];
    vec_t post[6];

    initial begin
        // Training (valid ignored), then data, back-to-back data, idle, idle with off-edge valid noise.
        tbl[0] = '{d: 8'h00, v: 1'b0, exp: 8'hBC, act: 1'b0, com: 1'b1};
        tbl[1] = '{d: 8'hFF, v: 1'b1, exp: 8'hBC, act: 1'b0, com: 1'b1};
        tbl[2] = '{d: 8'h00, v: 1'b0, exp: 8'hBC, act: 1'b0, com: 1'b1};
        tbl[3] = '{d: 8'h12, v: 1'b1, exp: 8'hBC, act: 1'b1, com: 1'b1};
        tbl[4] = '{d: 8'hA5, v: 1'b1, exp: 8'hA5, act: 1'b1, com: 1'b0};
        tbl[5] = '{d: 8'h3C, v: 1'b1, exp: 8'h3C, act: 1'b1, com: 1'b0};
        tbl[6] = '{d: 8'h00, v: 1'b0, exp: 8'h7C, act: 1'b1, com: 1'b0};
        tbl[7] = '{d: 8'hFF, v: 1'b0, exp: 8'h7C, act: 1'b1, com: 1'b0};
        tbl[8] = '{d: 8'h5A, v: 1'b1, exp: 8'h5A, act: 1'b1, com: 1'b0};
        tbl[9] = '{d: 8'hC3, v: 1'b1, exp: 8'hC3, act: 1'b1, com: 1'b0};

        // After mid-byte reset: fresh training with valid high, then 00 data, idle, 00 data.
        post[0] = '{d: 8'h11, v: 1'b1, exp: 8'hBC, act: 1'b0, com: 1'b1};
        post[1] = '{d: 8'h22, v: 1'b1, exp: 8'hBC, act: 1'b0, com: 1'b1};
        post[2] = '{d: 8'h33, v: 1'b1, exp: 8'hBC, act: 1'b0, com: 1'b1};
        post[3] = '{d: 8'h44, v: 1'b1, exp: 8'hBC, act: 1'b1, com: 1'b1};
        post[4] = '{d: 8'h00, v: 1'b1, exp: 8'h00, act: 1'b1, com: 1'b0};
        post[5] = '{d: 8'h00, v: 1'b0, exp: 8'h7C, act: 1'b1, com: 1'b0};

        // Reset held for 3 clocks.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("reset%0d data_out", i), 8'(data_out), 8'h00);
            chk($sformatf("reset%0d strobe", i), 8'(byte_strobe), 8'h00);
            chk($sformatf("reset%0d active", i), 8'(active), 8'h00);
        end
        reset_L = 1'b1;
        #1;
        chk("release data_out", 8'(data_out), 8'h00);
        chk("release strobe", 8'(byte_strobe), 8'h00);
        chk("release active", 8'(active), 8'h00);

        for (int i = 0; i < 10; i++) begin
            send_byte(tbl[i], $sformatf("tbl%0d", i), 8);
        end

        // Partial data byte, then asynchronous reset mid-cycle.
        send_byte('{d: 8'h96, v: 1'b1, exp: 8'h96, act: 1'b1, com: 1'b0}, "partial", 4);
        #2;
        reset_L = 1'b0;
        #1;
        chk("midreset data_out", 8'(data_out), 8'h00);
        chk("midreset strobe", 8'(byte_strobe), 8'h00);
        chk("midreset active", 8'(active), 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midreset held data_out", 8'(data_out), 8'h00);
        reset_L = 1'b1;
        #1;
        chk("rerelease data_out", 8'(data_out), 8'h00);

        for (int i = 0; i < 6; i++) begin
            send_byte(post[i], $sformatf("post%0d", i), 8);
        end
        send_byte('{d: 8'h00, v: 1'b1, exp: 8'h00, act: 1'b1, com: 1'b0}, "post6", 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
